// File: rtl/serial_pair_transmitter.sv
// Parallel-to-serial front end: captures an operand pair on a valid/ready
// handshake and shifts both words out in lockstep with first/last framing.
module serial_pair_transmitter #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_nxt;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             bit_valid_q, bit_valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             at_last;
    logic             accept;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // cnt_q is the index k of the bit currently on a/b while in SHIFT
    assign at_last = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    assign accept  = up_valid && up_ready;
    assign cnt_nxt = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (at_last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        up_ready = !rst && ((state_q == IDLE) || at_last);
    end

    always_comb begin
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        a_d         = 1'b0;
        b_d         = 1'b0;
        bit_valid_d = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        if (accept) begin
            // The first bit goes straight to the output flops; the shifter keeps the rest
            cnt_d       = '0;
            a_d         = head(up_a);
            b_d         = head(up_b);
            sh_a_d      = advance(up_a);
            sh_b_d      = advance(up_b);
            bit_valid_d = 1'b1;
            first_d     = 1'b1;
            last_d      = (WIDTH == 1);
        end else if (state_q == SHIFT && !at_last) begin
            cnt_d       = cnt_nxt;
            a_d         = head(sh_a_q);
            b_d         = head(sh_b_q);
            sh_a_d      = advance(sh_a_q);
            sh_b_d      = advance(sh_b_q);
            bit_valid_d = 1'b1;
            last_d      = (cnt_nxt == LAST_IDX);
        end else if (at_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            bit_valid_q <= bit_valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    // Shift registers hold data only; they are always reloaded before use
    always_ff @(posedge clk) begin
        sh_a_q <= sh_a_d;
        sh_b_q <= sh_b_d;
    end

    assign a         = a_q;
    assign b         = b_q;
    assign bit_valid = bit_valid_q;
    assign first     = first_q;
    assign last      = last_q;

endmodule
